// File: rtl/approx_mon_pkg.sv
// Shared types, default widths and the reference error function for the
// approximate-arithmetic characterisation monitors.
package approx_mon_pkg;

  localparam int DEF_W     = 16;
  localparam int DEF_CNT_W = 24;
  localparam int DEF_ACC_W = 48;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } mon_state_e;

  // Magnitude of (o_approx - (a + b)); always fits in DEF_W+1 bits.
  function automatic logic [DEF_W:0] abs_err(input logic [DEF_W:0]   o_approx,
                                             input logic [DEF_W-1:0] a,
                                             input logic [DEF_W-1:0] b);
    logic [DEF_W:0] exact;
    exact = {1'b0, a} + {1'b0, b};
    return (o_approx >= exact) ? (o_approx - exact) : (exact - o_approx);
  endfunction

endpackage

// File: rtl/approx_err_stage.sv
// First pipeline stage of the error monitor: registers the signed error of each
// accepted sample and presents its magnitude to the accumulating stage.
module approx_err_stage #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush_i,
  input  logic         valid_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic [W:0]   o_approx_i,
  output logic         valid_o,
  output logic [W-1:0] a_o,
  output logic [W-1:0] b_o,
  output logic [W:0]   abs_o,
  output logic         err_o
);

  logic [W:0]   exact_d;
  logic [W+1:0] e_d;
  logic [W+1:0] e_q;
  logic [W-1:0] a_q;
  logic [W-1:0] b_q;
  logic         valid_q;

  assign exact_d = {1'b0, a_i} + {1'b0, b_i};
  assign e_d     = {1'b0, o_approx_i} - {1'b0, exact_d};

  // A flush drops whatever is in flight so an aborted run leaves no trace.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      e_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      valid_q <= valid_i && !flush_i;
      if (valid_i) begin
        e_q <= e_d;
        a_q <= a_i;
        b_q <= b_i;
      end
    end
  end

  assign valid_o = valid_q;
  assign a_o     = a_q;
  assign b_o     = b_q;
  assign err_o   = |e_q;
  assign abs_o   = e_q[W+1] ? (W+1)'(~e_q + 1'b1) : e_q[W:0];

endmodule

// File: rtl/add16u_err_monitor.sv
// Streaming error-characterisation monitor for approximate unsigned adders:
// run control FSM, sample counters and the MAE/WCE/EP accumulators.
module add16u_err_monitor
  import approx_mon_pkg::*;
#(
  parameter int W     = DEF_W,
  parameter int CNT_W = DEF_CNT_W,
  parameter int ACC_W = DEF_ACC_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] n_samples,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  input  logic [W:0]       o_approx,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] samples,
  output logic [CNT_W-1:0] err_cnt,
  output logic [ACC_W-1:0] sae,
  output logic [W:0]       wce,
  output logic [W-1:0]     wce_a,
  output logic [W-1:0]     wce_b,
  output logic             sat
);

  mon_state_e       state_q;
  logic [CNT_W-1:0] n_q;
  logic [CNT_W-1:0] accepted_q;
  logic             done_q;
  logic             xfer;
  logic             last_xfer;

  logic             s1_valid;
  logic             s1_err;
  logic [W-1:0]     s1_a;
  logic [W-1:0]     s1_b;
  logic [W:0]       s1_abs;

  logic [CNT_W-1:0] samples_q;
  logic [CNT_W-1:0] err_cnt_q;
  logic [ACC_W-1:0] sae_q;
  logic [ACC_W:0]   sae_d;
  logic [W:0]       wce_q;
  logic [W-1:0]     wce_a_q;
  logic [W-1:0]     wce_b_q;
  logic             sat_q;

  assign in_ready  = (state_q == RUN) && (accepted_q < n_q);
  assign xfer      = in_valid && in_ready;
  assign last_xfer = xfer && ((accepted_q + CNT_W'(1)) == n_q);
  assign busy      = (state_q == RUN) || (state_q == DRAIN);
  assign done      = done_q;

  approx_err_stage #(.W(W)) u_stage (
    .clk        (clk),
    .rst        (rst),
    .flush_i    (start),
    .valid_i    (xfer),
    .a_i        (a),
    .b_i        (b),
    .o_approx_i (o_approx),
    .valid_o    (s1_valid),
    .a_o        (s1_a),
    .b_o        (s1_b),
    .abs_o      (s1_abs),
    .err_o      (s1_err)
  );

  // DRAIN lasts one cycle: nothing enters the pipeline there, so the last
  // sample leaves S1 on that edge and the statistics are final in DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      n_q        <= '0;
      accepted_q <= '0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start) begin
        n_q        <= n_samples;
        accepted_q <= '0;
        if (n_samples == '0) begin
          state_q <= DONE;
          done_q  <= 1'b1;
        end else begin
          state_q <= RUN;
        end
      end else begin
        case (state_q)
          RUN: begin
            if (xfer) begin
              accepted_q <= accepted_q + CNT_W'(1);
              if (last_xfer) state_q <= DRAIN;
            end
          end
          DRAIN: begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
          DONE:    state_q <= IDLE;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign sae_d = {1'b0, sae_q} + (ACC_W+1)'(s1_abs);

  // Second stage: fold each sample's error into the run statistics.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      samples_q <= '0;
      err_cnt_q <= '0;
      sae_q     <= '0;
      wce_q     <= '0;
      wce_a_q   <= '0;
      wce_b_q   <= '0;
      sat_q     <= 1'b0;
    end else if (start) begin
      samples_q <= '0;
      err_cnt_q <= '0;
      sae_q     <= '0;
      wce_q     <= '0;
      wce_a_q   <= '0;
      wce_b_q   <= '0;
      sat_q     <= 1'b0;
    end else if (s1_valid) begin
      samples_q <= samples_q + CNT_W'(1);
      if (s1_err) err_cnt_q <= err_cnt_q + CNT_W'(1);
      if (sae_d[ACC_W]) begin
        sae_q <= '1;
        sat_q <= 1'b1;
      end else begin
        sae_q <= sae_d[ACC_W-1:0];
      end
      if (s1_abs > wce_q) begin
        wce_q   <= s1_abs;
        wce_a_q <= s1_a;
        wce_b_q <= s1_b;
      end
    end
  end

  assign samples = samples_q;
  assign err_cnt = err_cnt_q;
  assign sae     = sae_q;
  assign wce     = wce_q;
  assign wce_a   = wce_a_q;
  assign wce_b   = wce_b_q;
  assign sat     = sat_q;

endmodule

// File: tb/tb_add16u_err_monitor.sv
// Self-checking bench for add16u_err_monitor: a sample-level reference model
// predicts every output each cycle; directed runs pin hand-computed results.
module tb_add16u_err_monitor;

  localparam longint MAX48 = 64'h0000_FFFF_FFFF_FFFF;
  localparam longint MAX18 = 64'd262143;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [23:0] n_samples = '0;
  logic        in_valid = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic [16:0] o_approx = '0;

  logic        in_ready, busy, done, sat;
  logic [23:0] samples, err_cnt;
  logic [47:0] sae;
  logic [16:0] wce;
  logic [15:0] wce_a, wce_b;

  logic        inReadySat, busySat, doneSat, satSat;
  logic [23:0] samplesSat, errCntSat;
  logic [17:0] saeSat;
  logic [16:0] wceSat;
  logic [15:0] wceASat, wceBSat;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int lastAcceptCyc = 0;

  add16u_err_monitor u_dut (
    .clk(clk), .rst(rst), .start(start), .n_samples(n_samples),
    .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .o_approx(o_approx),
    .busy(busy), .done(done), .samples(samples), .err_cnt(err_cnt), .sae(sae),
    .wce(wce), .wce_a(wce_a), .wce_b(wce_b), .sat(sat)
  );

  add16u_err_monitor #(.ACC_W(18)) u_sat (
    .clk(clk), .rst(rst), .start(start), .n_samples(n_samples),
    .in_valid(in_valid), .in_ready(inReadySat), .a(a), .b(b), .o_approx(o_approx),
    .busy(busySat), .done(doneSat), .samples(samplesSat), .err_cnt(errCntSat),
    .sae(saeSat), .wce(wceSat), .wce_a(wceASat), .wce_b(wceBSat), .sat(satSat)
  );

  always #5 clk = ~clk;

  // Reference model state: statistics as visible in the current cycle.
  typedef struct {int vis; int sa; int sb; int so;} pend_t;
  pend_t  pendQ[$];
  bit     mStarted, mInReady, mBusy, mDone, mSat48, mSat18;
  int     mN, mAcc, mDoneAt, mBusyUntil;
  longint mSamples, mErr, mSae48, mSae18, mWce, mWa, mWb;

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic failNow(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s actual=timeout expected=event (cycle %0d)", name, cyc);
  endtask

  task automatic clearStats();
    mSamples = 0; mErr = 0; mSae48 = 0; mSae18 = 0; mWce = 0; mWa = 0; mWb = 0;
    mSat48 = 0; mSat18 = 0;
    pendQ.delete();
  endtask

  task automatic absorb(input pend_t p);
    int e, ae;
    e  = p.so - (p.sa + p.sb);
    ae = (e < 0) ? -e : e;
    mSamples++;
    if (e != 0) mErr++;
    if (mSae48 + ae > MAX48) begin mSae48 = MAX48; mSat48 = 1; end else mSae48 += ae;
    if (mSae18 + ae > MAX18) begin mSae18 = MAX18; mSat18 = 1; end else mSae18 += ae;
    if (ae > mWce) begin mWce = ae; mWa = p.sa; mWb = p.sb; end
  endtask

  // Model: a sample accepted in cycle t is visible at t+2; done two cycles
  // after the last accept, or one cycle after a zero-length start.
  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        clearStats();
        mStarted = 0; mN = 0; mAcc = 0; mDoneAt = -1; mBusyUntil = -1;
      end else if (start) begin
        clearStats();
        mStarted = 1; mN = int'(n_samples); mAcc = 0;
        mDoneAt    = (mN == 0) ? cyc + 1 : -1;
        mBusyUntil = (mN == 0) ? -1 : 32'h7fff_ffff;
      end else if (mInReady && in_valid) begin
        pendQ.push_back('{cyc + 2, int'(a), int'(b), int'(o_approx)});
        mAcc++;
        if (mAcc == mN) begin mDoneAt = cyc + 2; mBusyUntil = cyc + 1; end
      end
      cyc++;
      while (pendQ.size() > 0 && pendQ[0].vis <= cyc) absorb(pendQ.pop_front());
      mInReady = mStarted && (mAcc < mN);
      mBusy    = mStarted && (cyc <= mBusyUntil);
      mDone    = (cyc == mDoneAt);
    end
  end

  // Compare process: every output of both instances, every cycle out of reset.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        checkOutput("in_ready", in_ready, mInReady);
        checkOutput("busy", busy, mBusy);
        checkOutput("done", done, mDone);
        checkOutput("samples", samples, mSamples);
        checkOutput("err_cnt", err_cnt, mErr);
        checkOutput("sae", sae, mSae48);
        checkOutput("sat", sat, mSat48);
        checkOutput("wce", wce, mWce);
        checkOutput("wce_a", wce_a, mWa);
        checkOutput("wce_b", wce_b, mWb);
        checkOutput("in_ready_18", inReadySat, mInReady);
        checkOutput("busy_18", busySat, mBusy);
        checkOutput("done_18", doneSat, mDone);
        checkOutput("samples_18", samplesSat, mSamples);
        checkOutput("err_cnt_18", errCntSat, mErr);
        checkOutput("sae_18", saeSat, mSae18);
        checkOutput("sat_18", satSat, mSat18);
        checkOutput("wce_18", wceSat, mWce);
        checkOutput("wce_a_18", wceASat, mWa);
        checkOutput("wce_b_18", wceBSat, mWb);
      end
    end
  end

  task automatic doStart(input int n);
    @(negedge clk);
    start = 1'b1; n_samples = 24'(n); in_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Offer one sample until it is handshaked; holdPct sets in_valid density.
  task automatic applyStimulus(input int ta, input int tb, input int to, input int holdPct);
    int  guard;
    bit  sent;
    guard = 0;
    sent  = 0;
    while (!sent) begin
      @(negedge clk);
      a = 16'(ta); b = 16'(tb); o_approx = 17'(to);
      in_valid = (int'($urandom_range(99)) < holdPct);
      #1;
      if (in_valid && in_ready) begin
        sent = 1;
        lastAcceptCyc = cyc;
      end else begin
        guard++;
        if (guard > 500) begin failNow("handshake"); sent = 1; end
      end
    end
  endtask

  task automatic randomSample(output int ra, output int rb, output int ro);
    int ex;
    ra = int'($urandom_range(65535));
    rb = int'($urandom_range(65535));
    ex = ra + rb;
    case ($urandom_range(3))
      0:       ro = ex;
      1:       ro = int'($urandom_range(131071));
      default: begin
        ro = ex + int'($urandom_range(64)) - 32;
        if (ro < 0) ro = 0;
        if (ro > 131071) ro = 131071;
      end
    endcase
  endtask

  task automatic waitDone(input int budget, output int dc);
    dc = -1;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (done) begin dc = cyc; break; end
    end
    if (dc < 0) failNow("done_wait");
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int dc, ra, rb, ro, firstAcc;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("reset_in_ready", in_ready, 0);
    checkOutput("reset_samples", samples, 0);
    checkOutput("reset_sae", sae, 0);

    // Exact stream
    doStart(4);
    applyStimulus(1, 2, 3, 100);
    applyStimulus(100, 20, 120, 100);
    applyStimulus(65535, 65535, 131070, 100);
    applyStimulus(0, 0, 0, 100);
    waitDone(20, dc);
    checkOutput("exact_latency", dc - lastAcceptCyc, 2);
    checkOutput("exact_samples", samples, 4);
    checkOutput("exact_sae", sae, 0);
    checkOutput("exact_wce", wce, 0);
    checkOutput("exact_err_cnt", err_cnt, 0);

    // Mixed errors
    doStart(3);
    applyStimulus(100, 20, 128, 100);
    applyStimulus(7, 9, 0, 100);
    applyStimulus(5, 5, 10, 100);
    waitDone(20, dc);
    checkOutput("mixed_sae", sae, 24);
    checkOutput("mixed_wce", wce, 16);
    checkOutput("mixed_wce_a", wce_a, 7);
    checkOutput("mixed_wce_b", wce_b, 9);
    checkOutput("mixed_err_cnt", err_cnt, 2);

    // Tie rule
    doStart(2);
    applyStimulus(1, 1, 26, 100);
    applyStimulus(2, 2, 28, 100);
    waitDone(20, dc);
    checkOutput("tie_wce", wce, 24);
    checkOutput("tie_wce_a", wce_a, 1);
    checkOutput("tie_wce_b", wce_b, 1);

    // Random backpressure
    doStart(20);
    for (int i = 0; i < 20; i++) begin
      randomSample(ra, rb, ro);
      applyStimulus(ra, rb, ro, 50);
    end
    waitDone(20, dc);
    checkOutput("bp_samples", samples, 20);

    // Zero-length run
    doStart(0);
    checkOutput("zero_done", done, 1);
    checkOutput("zero_samples", samples, 0);
    checkOutput("zero_busy", busy, 0);

    // Continuous stream of 1000
    doStart(1000);
    for (int i = 0; i < 1000; i++) begin
      randomSample(ra, rb, ro);
      applyStimulus(ra, rb, ro, 100);
      if (i == 0) firstAcc = lastAcceptCyc;
    end
    waitDone(20, dc);
    checkOutput("stream_no_bubbles", lastAcceptCyc - firstAcc, 999);
    checkOutput("stream_latency", dc - lastAcceptCyc, 2);
    checkOutput("stream_samples", samples, 1000);

    // Abort with samples still in flight
    doStart(10);
    for (int i = 0; i < 5; i++) applyStimulus(10 + i, 3, 200, 100);
    doStart(2);
    checkOutput("abort_samples_cleared", samples, 0);
    applyStimulus(4, 4, 8, 100);
    applyStimulus(9, 1, 10, 100);
    waitDone(20, dc);
    checkOutput("abort_samples", samples, 2);
    checkOutput("abort_sae", sae, 0);
    checkOutput("abort_err_cnt", err_cnt, 0);

    // Saturation of the 18-bit accumulator
    doStart(3);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 131071, 100);
    waitDone(20, dc);
    checkOutput("sat_sae18", saeSat, 262143);
    checkOutput("sat_flag18", satSat, 1);
    repeat (4) @(negedge clk);
    checkOutput("sat_hold18", satSat, 1);
    doStart(0);
    checkOutput("sat_clear18", satSat, 0);

    // Asynchronous reset mid-run
    doStart(10);
    for (int i = 0; i < 4; i++) applyStimulus(50, 50, 90 + i, 100);
    @(posedge clk);
    #2;
    rst = 1'b1;
    in_valid = 1'b0;
    #1;
    checkOutput("rst_in_ready", in_ready, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_samples", samples, 0);
    checkOutput("rst_err_cnt", err_cnt, 0);
    checkOutput("rst_sae", sae, 0);
    checkOutput("rst_wce", wce, 0);
    checkOutput("rst_wce_a", wce_a, 0);
    checkOutput("rst_wce_b", wce_b, 0);
    checkOutput("rst_sat", sat, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
